scan_seq_ctrl: RTL and testbench
================================

# scan_seq_ctrl

Scan test sequencer for the scan-inserted s9234 core. It streams stimulus bits from a pattern source into the scan chain and issues one capture cycle per pattern. It unloads each captured response while the next pattern loads, compares every unloaded bit against an expected bit, and reports a saturating mismatch count and a pass flag. It sits between the bench or BIST pattern source and the core's scan-enable, scan-in and scan-out pins.

## Interface
- CHAIN_LEN, 211: flip-flops in the scan chain.
- NUM_PAT, 16: patterns per run (≥1).
- CNT_W, 8: bit/pattern counter width; must satisfy 2^CNT_W > max(CHAIN_LEN, NUM_PAT).
- ERR_W, 16: mismatch counter width.

- CK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- si_valid  in  1  source has a stimulus/expect bit pair.
- si_bit  in  1  stimulus bit for scan_in.
- si_exp  in  1  expected value of scan_out for this shift.
- si_ready  out  1  sequencer accepts a pair this cycle.
- scan_en  out  1  core shift enable; low means functional capture.
- scan_in  out  1  serial data to the chain head.
- scan_out  in  1  serial data from the chain tail.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result of the last completed run.
- err_cnt  out  ERR_W  saturating mismatch count of the current or last run.
- pat_idx  out  CNT_W  patterns captured so far in this run.

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE. State is registered; outputs marked combinational decode from the state and inputs.
- **IDLE**
  - start=1 clears err_cnt, pat_idx, bit counter and pass, then moves to SHIFT.
  - start in any other state is ignored.
- **SHIFT**
  - si_ready=1.
  - Handshake = si_valid & si_ready.
  - scan_en = handshake (combinational). The chain advances only on handshake cycles.
  - scan_in = si_bit.
  - On each handshake edge the bit counter increments.
  - If pat_idx>0, compare scan_out against si_exp; a mismatch adds 1 to err_cnt. On the first load pat_idx=0 and si_exp is ignored.
  - After the CHAIN_LEN-th handshake the bit counter clears and the state moves to CAPTURE.
- **CAPTURE**
  - Exactly one cycle; scan_en=0, si_ready=0.
  - pat_idx increments.
  - Next state is UNLOAD if the new pat_idx equals NUM_PAT, otherwise SHIFT.
- **UNLOAD**
  - Same handshake, scan_en and comparison rules as SHIFT, but scan_in=0 and si_bit is ignored. Comparison always applies.
  - After CHAIN_LEN handshakes the state moves to DONE.
- **DONE**
  - One cycle: done=1, pass=(err_cnt==0), then IDLE.
  - pass and err_cnt hold until the next accepted start.
- **Arithmetic**
  - err_cnt saturates at 2^ERR_W−1 and never wraps.
  - A mismatch on the final UNLOAD handshake is counted before pass is evaluated.
- **Reset**
  - RST_N low forces IDLE at once, from any state including mid-shift.
  - All outputs go to 0: scan_en, scan_in, si_ready, busy, done, pass, err_cnt, pat_idx.
  - The chain contents are then undefined; a fresh start reloads them.

## Timing
- **Start latency:** start sampled at edge E0 → SHIFT from E0; first possible handshake at E1.
- **Run length:** with si_valid held at 1, the last UNLOAD handshake occurs at edge E(NUM_PAT·(CHAIN_LEN+1)+CHAIN_LEN). done is high in the following cycle, and busy falls one edge later.
- **Stalls:** each cycle with si_valid=0 in SHIFT or UNLOAD extends the run by one cycle. During a stall scan_en=0 and no counter or compare activity occurs.
- **Capture separation:** at least one scan_en=0 cycle lies between the last load shift and the first unload shift of each pattern.
- **Compare sampling:** scan_out is sampled at the same edge that shifts the chain, i.e. the tail bit before the shift.

## Test plan
- **Reset:** assert RST_N=0 mid-SHIFT, CHAIN_LEN=211 → all outputs 0 within the same cycle; busy=0; no done pulse; a following start runs a full sequence.
- **Clean run:** loopback bench with a 4-FF chain model (CHAIN_LEN=4, NUM_PAT=2) whose capture XORs the chain with 4'b1010; si_valid=1 and correct si_exp → done at the cycle after E14, pass=1, err_cnt=0, pat_idx=2.
- **Single fault:** same setup, one si_exp bit of pattern 2's unload inverted → err_cnt=1, pass=0.
- **Stalls:** same setup, si_valid=0 for 3 cycles mid-load of pattern 1 → scan_en=0 during the stall, done delayed exactly 3 cycles, pass=1.
- **Start while busy:** start pulsed during SHIFT → ignored; pat_idx and err_cnt unaffected.
- **Saturation:** ERR_W=2, every si_exp inverted → err_cnt=3 (no wrap), pass=0.

Source files
------------

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: loads scan patterns, issues one capture per pattern, and
// compares each unloaded response bit against a streamed expected bit.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; pass / err_cnt / pat_idx hold
// SHIFT   | loading a pattern; unloading the previous response if pat_idx>0
// CAPTURE | single functional clock (scan_en low), pat_idx advances
// UNLOAD  | draining the last response, scan_in forced to 0
// DONE    | one-cycle done pulse, then back to IDLE
module scan_seq_ctrl #(
    parameter int CHAIN_LEN = 211,
    parameter int NUM_PAT   = 16,
    parameter int CNT_W     = 8,
    parameter int ERR_W     = 16
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             si_valid,
    input  logic             si_bit,
    input  logic             si_exp,
    output logic             si_ready,
    output logic             scan_en,
    output logic             scan_in,
    input  logic             scan_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] pat_idx
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             hs;
    logic             last_bit;
    logic             cmp_en;
    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;

    // The chain only moves on a handshake, so scan_en is the handshake itself.
    assign hs       = si_valid & si_ready;
    assign scan_en  = hs;
    assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

    // The first load has no response behind it, so its expect bits are ignored.
    assign cmp_en   = hs && ((state == S_UNLOAD) ||
                             ((state == S_SHIFT) && (pat_idx != '0)));
    assign mismatch = cmp_en && (scan_out != si_exp);
    assign err_nxt  = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

    // State register; reset drops straight to IDLE even mid-shift.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_nxt = state;
        si_ready  = 1'b0;
        scan_in   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                si_ready = 1'b1;
                scan_in  = si_bit;
                if (hs && last_bit) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // pat_idx is incremented on this edge, so compare against NUM_PAT-1.
                state_nxt = (pat_idx == CNT_W'(NUM_PAT - 1)) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                si_ready = 1'b1;
                if (hs && last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit/pattern counters, saturating error count and pass flag.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt <= '0;
            pat_idx <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            bit_cnt <= '0;
            pat_idx <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            if (hs) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                err_cnt <= err_nxt;
                // Judged on the last unload edge using err_nxt so a final-bit
                // mismatch counts and pass is already valid while done is high.
                if ((state == S_UNLOAD) && last_bit) begin
                    pass <= (err_nxt == '0);
                end
            end
            if (state == S_CAPTURE) begin
                pat_idx <= pat_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: 4-FF chain model with XOR-1010 capture, randomized
// runs scored per cycle and per completed run against a pattern-level model.
module tb_scan_seq_ctrl;

    localparam int L       = 4;
    localparam int N       = 2;
    localparam int EW      = 2;
    localparam int CW      = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          CK = 1'b0;
    logic          RST_N;
    logic          start, si_valid, si_bit, si_exp;
    logic          si_ready, scan_en, scan_in, scan_out;
    logic          busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic [CW-1:0] pat_idx;

    typedef struct {
        logic          ready, se, sin, bsy, dn, ps;
        logic [EW-1:0] err;
        logic [CW-1:0] pat;
    } cyc_exp_t;

    typedef struct {
        logic [EW-1:0] err;
        logic          ps;
        logic [CW-1:0] pat;
    } res_t;

    cyc_exp_t cyc_q[$];
    res_t     res_q[$];
    cyc_exp_t mon_x;
    res_t     mon_r;

    int tests = 0;
    int fails = 0;
    int cur_err = 0;
    logic cur_pass = 1'b0;
    int cur_pat = 0;

    logic [L-1:0] cap_mask = 4'b1010;
    logic [L-1:0] chain;

    scan_seq_ctrl #(
        .CHAIN_LEN(L), .NUM_PAT(N), .CNT_W(CW), .ERR_W(EW)
    ) dut (
        .CK(CK), .RST_N(RST_N), .start(start), .si_valid(si_valid),
        .si_bit(si_bit), .si_exp(si_exp), .si_ready(si_ready),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .pat_idx(pat_idx)
    );

    always #5 CK = ~CK;

    // Core chain model: shift on scan_en, capture (XOR mask) in the capture cycle.
    assign scan_out = chain[L-1];
    always @(posedge CK) begin
        if (scan_en) chain <= {chain[L-2:0], scan_in};
        else if (busy && !si_ready && !done) chain <= chain ^ cap_mask;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cyc_exp_t mk(input logic rdy, se, sin, bsy, dn, ps);
        cyc_exp_t x;
        x.ready = rdy; x.se = se; x.sin = sin; x.bsy = bsy; x.dn = dn; x.ps = ps;
        x.err = EW'(cur_err);
        x.pat = CW'(cur_pat);
        return x;
    endfunction

    function automatic logic st_rand(input int mode);
        return (mode == 2 || mode == 3) ? 1'($urandom) : 1'b0;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_scan_en"},  32'(scan_en),  32'd0);
        chk({tag, "_scan_in"},  32'(scan_in),  32'd0);
        chk({tag, "_si_ready"}, 32'(si_ready), 32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_pass"},     32'(pass),     32'd0);
        chk({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
        chk({tag, "_pat_idx"},  32'(pat_idx),  32'd0);
    endtask

    task automatic drive(input logic v, b, e, st, input cyc_exp_t x);
        @(negedge CK);
        si_valid = v; si_bit = b; si_exp = e; start = st;
        cyc_q.push_back(x);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, mk(0, 0, 0, 0, 0, cur_pass));
    endtask

    // One scheduled cycle of a run, or the mid-run reset when its turn comes.
    task automatic step(input logic v, b, e, st, input cyc_exp_t x,
                        input int abort_at, inout int run_cyc, inout bit ab);
        if (ab) return;
        run_cyc++;
        if (run_cyc == abort_at) begin
            @(negedge CK);
            RST_N = 1'b0; start = 1'b1; si_valid = 1'b1; si_bit = 1'b1;
            #1;
            check_all_zero("mid_reset");
            void'(res_q.pop_back());
            @(negedge CK);
            start = 1'b0;
            RST_N = 1'b1;
            ab = 1'b1;
            return;
        end
        drive(v, b, e, st, x);
    endtask

    // mode: 0 clean, 1 single unload fault, 2 3-cycle stall + start pulses,
    //       3 random stalls/faults/start pulses, 4 every expect bit inverted
    task automatic do_run(input int mode, input int abort_at);
        logic stim [0:N][0:L-1];
        logic inv  [0:N][0:L-1];
        int   stl  [0:N][0:L-1];
        int   nerr, run_cyc, fk;
        bit   ab;
        logic b, e;
        res_t r;
        nerr = 0; run_cyc = 0; ab = 1'b0;
        fk = int'($urandom_range(L - 1));
        for (int p = 0; p <= N; p++) begin
            for (int k = 0; k < L; k++) begin
                stim[p][k] = 1'($urandom);
                case (mode)
                    1:       inv[p][k] = (p == N) && (k == fk);
                    3:       inv[p][k] = ($urandom_range(5) == 0);
                    4:       inv[p][k] = 1'b1;
                    default: inv[p][k] = 1'b0;
                endcase
                if (mode == 3)
                    stl[p][k] = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
                else
                    stl[p][k] = (mode == 2 && p == 0 && k == 2) ? 3 : 0;
                if (p > 0 && inv[p][k]) nerr++;
            end
        end
        r.err = EW'((nerr > ERR_MAX) ? ERR_MAX : nerr);
        r.ps  = (nerr == 0);
        r.pat = CW'(N);
        res_q.push_back(r);

        step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1,
             mk(0, 0, 0, 0, 0, cur_pass), abort_at, run_cyc, ab);
        cur_err = 0; cur_pass = 1'b0; cur_pat = 0;

        for (int p = 0; p <= N; p++) begin
            for (int k = 0; k < L; k++) begin
                for (int s = 0; s < stl[p][k]; s++) begin
                    b = 1'($urandom);
                    step(1'b0, b, 1'($urandom), st_rand(mode),
                         mk(1, 0, (p < N) ? b : 1'b0, 1, 0, 0), abort_at, run_cyc, ab);
                end
                b = (p < N) ? stim[p][k] : 1'($urandom);
                if (p == 0) e = 1'($urandom);
                else        e = stim[p-1][k] ^ cap_mask[L-1-k] ^ inv[p][k];
                step(1'b1, b, e, st_rand(mode),
                     mk(1, 1, (p < N) ? b : 1'b0, 1, 0, 0), abort_at, run_cyc, ab);
                if (p > 0 && inv[p][k] && cur_err < ERR_MAX) cur_err++;
            end
            if (p < N) begin
                step(1'($urandom), 1'($urandom), 1'($urandom), st_rand(mode),
                     mk(0, 0, 0, 1, 0, 0), abort_at, run_cyc, ab);
                cur_pat++;
            end
        end
        step(1'($urandom), 1'($urandom), 1'($urandom), st_rand(mode),
             mk(0, 0, 0, 1, 1, (cur_err == 0)), abort_at, run_cyc, ab);
        cur_pass = (cur_err == 0);
        if (ab) begin
            cur_err = 0; cur_pass = 1'b0; cur_pat = 0;
        end
        idle_cycles(2);
    endtask

    // Monitor: per-cycle expectations, plus end-of-run results on each done pulse.
    always @(negedge CK) begin
        #2;
        if (cyc_q.size() > 0) begin
            mon_x = cyc_q.pop_front();
            chk("si_ready", 32'(si_ready), 32'(mon_x.ready));
            chk("scan_en",  32'(scan_en),  32'(mon_x.se));
            chk("scan_in",  32'(scan_in),  32'(mon_x.sin));
            chk("busy",     32'(busy),     32'(mon_x.bsy));
            chk("done",     32'(done),     32'(mon_x.dn));
            chk("pass",     32'(pass),     32'(mon_x.ps));
            chk("err_cnt",  32'(err_cnt),  32'(mon_x.err));
            chk("pat_idx",  32'(pat_idx),  32'(mon_x.pat));
        end
        if (done) begin
            if (res_q.size() == 0) begin
                chk("done_without_run", 32'd1, 32'd0);
            end else begin
                mon_r = res_q.pop_front();
                chk("run_err_cnt", 32'(err_cnt), 32'(mon_r.err));
                chk("run_pass",    32'(pass),    32'(mon_r.ps));
                chk("run_pat_idx", 32'(pat_idx), 32'(mon_r.pat));
            end
        end
    end

    initial begin
        RST_N = 1'b0; start = 1'b0; si_valid = 1'b0; si_bit = 1'b0; si_exp = 1'b0;
        repeat (3) @(negedge CK);
        #1;
        check_all_zero("reset");
        @(negedge CK);
        RST_N = 1'b1;
        idle_cycles(2);

        do_run(0, 0);
        do_run(1, 0);
        do_run(2, 0);
        do_run(4, 0);
        do_run(0, 4);
        do_run(0, 0);
        for (int i = 0; i < 12; i++) do_run(3, 0);
        do_run(4, 0);

        idle_cycles(3);
        @(negedge CK);
        #3;
        chk("results_left", 32'(res_q.size()), 32'd0);
        chk("cycles_left",  32'(cyc_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, expected end before %0t", $time);
        $fatal(1);
    end

endmodule
